fcmp_arb: RTL and testbench

FCMP_ARB -- requirements
Module: fcmp_arb

---
 rtl/fcmp_pkg.sv | 39 +++
 rtl/fcmp_core.sv | 29 ++
 rtl/fcmp_arb.sv | 156 +++++++++++++++
 tb/tb_fcmp_arb.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/fcmp_pkg.sv
// fcmp_pkg: shared constants for the floating-point compare arbiter.
//   - operand width and IEEE-754 single field widths
//   - compare opcode encodings
//   - fcmp_key(): maps a single-precision word to an unsigned, order-preserving key
package fcmp_pkg;

    localparam int unsigned FP_W  = 32;
    localparam int unsigned EXP_W = 8;
    localparam int unsigned MAN_W = 23;

    // Key for every operand with a zero exponent (+/-0 and denormals flush here).
    localparam logic [FP_W-1:0] KEY_ZERO = 32'h8000_0000;

    typedef enum logic [1:0] {
        OP_LT  = 2'b00,
        OP_LE  = 2'b01,
        OP_EQ  = 2'b10,
        OP_RSV = 2'b11
    } fcmp_op_e;

    // Positive values get the top bit set so they sort above all negatives; negative values
    // have exponent/mantissa inverted so larger magnitude sorts lower.
    function automatic logic [FP_W-1:0] fcmp_key(input logic [FP_W-1:0] x);
        logic             sign;
        logic [EXP_W-1:0] e;
        logic [MAN_W-1:0] m;
        sign = x[FP_W-1];
        e    = x[FP_W-2 -: EXP_W];
        m    = x[MAN_W-1:0];
        if (e == '0) begin
            fcmp_key = KEY_ZERO;
        end else if (!sign) begin
            fcmp_key = {1'b1, e, m};
        end else begin
            fcmp_key = {1'b0, ~e, ~m};
        end
    endfunction

endpackage

// File: rtl/fcmp_core.sv
// fcmp_core: combinational single-precision compare.
//   x1, x2 : operands (IEEE-754 single)
//   op     : 00 LT, 01 LE, 10 EQ, 11 reserved (result 0)
//   result : compare outcome
// NaNs get no special treatment; they order by their key like any other value.
module fcmp_core
    import fcmp_pkg::*;
(
    input  logic [FP_W-1:0] x1,
    input  logic [FP_W-1:0] x2,
    input  logic [1:0]      op,
    output logic            result
);

    logic [FP_W-1:0] k1;
    logic [FP_W-1:0] k2;

    always_comb begin
        k1 = fcmp_key(x1);
        k2 = fcmp_key(x2);
        case (op)
            OP_LT:   result = (k1 < k2);
            OP_LE:   result = (k1 <= k2);
            OP_EQ:   result = (k1 == k2);
            default: result = 1'b0;
        endcase
    end

endmodule

// File: rtl/fcmp_arb.sv
// fcmp_arb: round-robin arbiter in front of a 2-stage floating-point compare pipeline.
//   clk, rstn  : clock, asynchronous active-low reset
//   req_valid  : per-requester request;  req_ready: one-hot (or zero) accept
//   req_x1/x2  : packed operands, requester i at [32i+31:32i]
//   req_op     : packed opcodes, requester i at [2i+1:2i]
//   rsp_valid  : one-cycle response pulse to the requester, two cycles after its grant
//   rsp_y      : result word, bit 0 = outcome, zero when no response completes
//   busy       : an operation is in either pipeline stage
//   stat_cnt   : saturating accepted-request count when FCMP_ARB_STATS_EN is defined, else 0
module fcmp_arb
    import fcmp_pkg::*;
#(
    parameter int unsigned NREQ = 4
) (
    input  logic                   clk,
    input  logic                   rstn,
    input  logic [NREQ-1:0]        req_valid,
    output logic [NREQ-1:0]        req_ready,
    input  logic [FP_W*NREQ-1:0]   req_x1,
    input  logic [FP_W*NREQ-1:0]   req_x2,
    input  logic [2*NREQ-1:0]      req_op,
    output logic [NREQ-1:0]        rsp_valid,
    output logic [31:0]            rsp_y,
    output logic                   busy,
    output logic [15:0]            stat_cnt
);

    localparam int unsigned IW = (NREQ > 1) ? $clog2(NREQ) : 1;

    logic [IW-1:0]   ptr_q, ptr_d;
    logic            gnt_any;
    logic [IW-1:0]   gnt_idx;
    logic [FP_W-1:0] x1_sel, x2_sel;
    logic [1:0]      op_sel;

    logic            s1_valid_q;
    logic [IW-1:0]   s1_idx_q;
    logic [FP_W-1:0] s1_x1_q, s1_x2_q;
    logic [1:0]      s1_op_q;
    logic            s1_res;

    logic [NREQ-1:0] rsp_valid_d, rsp_valid_q;
    logic            rsp_bit_q;

    // Rotating priority search starting at ptr_q.
    always_comb begin
        int unsigned   cand;
        logic [IW-1:0] cand_idx;
        gnt_any  = 1'b0;
        gnt_idx  = '0;
        cand     = 0;
        cand_idx = '0;
        for (int unsigned off = 0; off < NREQ; off++) begin
            cand     = (int'(ptr_q) + off) % NREQ;
            cand_idx = cand[IW-1:0];
            if (!gnt_any && req_valid[cand_idx]) begin
                gnt_any = 1'b1;
                gnt_idx = cand_idx;
            end
        end
    end

    always_comb begin
        req_ready = '0;
        if (rstn && gnt_any) begin
            req_ready[gnt_idx] = 1'b1;
        end
    end

    always_comb begin
        ptr_d = ptr_q;
        if (gnt_any) begin
            ptr_d = (gnt_idx == IW'(NREQ - 1)) ? '0 : gnt_idx + 1'b1;
        end
    end

    always_comb begin
        x1_sel = '0;
        x2_sel = '0;
        op_sel = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (gnt_idx == IW'(i)) begin
                x1_sel = req_x1[i*FP_W +: FP_W];
                x2_sel = req_x2[i*FP_W +: FP_W];
                op_sel = req_op[i*2 +: 2];
            end
        end
    end

    // Stage 1: granted operation captured.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            ptr_q      <= '0;
            s1_valid_q <= 1'b0;
            s1_idx_q   <= '0;
            s1_x1_q    <= '0;
            s1_x2_q    <= '0;
            s1_op_q    <= '0;
        end else begin
            ptr_q      <= ptr_d;
            s1_valid_q <= gnt_any;
            if (gnt_any) begin
                s1_idx_q <= gnt_idx;
                s1_x1_q  <= x1_sel;
                s1_x2_q  <= x2_sel;
                s1_op_q  <= op_sel;
            end
        end
    end

    fcmp_core u_core (
        .x1     (s1_x1_q),
        .x2     (s1_x2_q),
        .op     (s1_op_q),
        .result (s1_res)
    );

    always_comb begin
        rsp_valid_d = '0;
        if (s1_valid_q) begin
            rsp_valid_d[s1_idx_q] = 1'b1;
        end
    end

    // Stage 2: registered response; never back-pressured.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rsp_valid_q <= '0;
            rsp_bit_q   <= 1'b0;
        end else begin
            rsp_valid_q <= rsp_valid_d;
            rsp_bit_q   <= s1_valid_q & s1_res;
        end
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_y     = {31'b0, rsp_bit_q};
    assign busy      = s1_valid_q | (|rsp_valid_q);

`ifdef FCMP_ARB_STATS_EN
    logic [15:0] stat_q;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            stat_q <= '0;
        end else if (gnt_any && (stat_q != 16'hFFFF)) begin
            stat_q <= stat_q + 16'd1;
        end
    end

    assign stat_cnt = stat_q;
`else
    assign stat_cnt = '0;
`endif

endmodule

// File: tb/tb_fcmp_arb.sv
// tb_fcmp_arb: self-checking bench for fcmp_arb (NREQ = 4) with a behavioural model and
// a per-cycle compare process, plus literal expectations for the directed scenarios.
module tb_fcmp_arb;

    localparam int unsigned NREQ = 4;

    logic              clk  = 1'b0;
    logic              rstn = 1'b0;
    logic [NREQ-1:0]   req_valid;
    logic [NREQ-1:0]   req_ready;
    logic [32*NREQ-1:0] req_x1;
    logic [32*NREQ-1:0] req_x2;
    logic [2*NREQ-1:0] req_op;
    logic [NREQ-1:0]   rsp_valid;
    logic [31:0]       rsp_y;
    logic              busy;
    logic [15:0]       stat_cnt;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    fcmp_arb #(.NREQ(NREQ)) dut (
        .clk       (clk),
        .rstn      (rstn),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_x1    (req_x1),
        .req_x2    (req_x2),
        .req_op    (req_op),
        .rsp_valid (rsp_valid),
        .rsp_y     (rsp_y),
        .busy      (busy),
        .stat_cnt  (stat_cnt)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s (cycle %0d): got 0x%0h, want 0x%0h", name, cyc, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // ---------------- behavioural model ----------------
    typedef struct {
        int due;
        int idx;
        bit res;
    } exp_t;

    exp_t mq[$];
    int   m_ptr = 0;
    int   m_cnt = 0;

    // Ordering key: zero exponent -> +0; positives above all negatives; negatives reversed.
    function automatic logic [31:0] mkey(input logic [31:0] x);
        if (x[30:23] == 8'd0) return 32'h8000_0000;
        if (x[31]) return ~x;
        return x | 32'h8000_0000;
    endfunction

    function automatic bit model_cmp(input logic [31:0] a, input logic [31:0] b,
                                     input logic [1:0] op);
        logic [31:0] ka, kb;
        ka = mkey(a);
        kb = mkey(b);
        case (op)
            2'd0:    return ka < kb;
            2'd1:    return ka <= kb;
            2'd2:    return ka == kb;
            default: return 1'b0;
        endcase
    endfunction

    always @(negedge clk) begin
        logic [NREQ-1:0] exp_v;
        logic [NREQ-1:0] exp_rdy;
        logic [31:0]     exp_y;
        logic [15:0]     exp_stat;
        logic            exp_busy;
        int              g;
        if (!rstn) begin
            check("rst_ready", 32'(req_ready), 32'd0);
            check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
            check("rst_rsp_y", rsp_y, 32'd0);
            check("rst_busy", 32'(busy), 32'd0);
            check("rst_stat", 32'(stat_cnt), 32'd0);
            mq.delete();
            m_ptr = 0;
            m_cnt = 0;
        end else begin
            exp_v    = '0;
            exp_y    = '0;
            exp_busy = 1'b0;
            foreach (mq[i]) begin
                if (mq[i].due == cyc) begin
                    exp_v[mq[i].idx] = 1'b1;
                    exp_y = {31'd0, mq[i].res};
                end
                if (mq[i].due == cyc || mq[i].due == cyc + 1) exp_busy = 1'b1;
            end
            check("m_rsp_valid", 32'(rsp_valid), 32'(exp_v));
            check("m_rsp_y", rsp_y, exp_y);
            check("m_busy", 32'(busy), 32'(exp_busy));
`ifdef FCMP_ARB_STATS_EN
            exp_stat = (m_cnt > 65535) ? 16'hFFFF : 16'(m_cnt);
`else
            exp_stat = 16'd0;
`endif
            check("m_stat", 32'(stat_cnt), 32'(exp_stat));

            g = -1;
            for (int off = 0; off < NREQ; off++) begin
                if (g < 0 && req_valid[(m_ptr + off) % NREQ]) g = (m_ptr + off) % NREQ;
            end
            exp_rdy = '0;
            if (g >= 0) exp_rdy[g] = 1'b1;
            check("m_ready", 32'(req_ready), 32'(exp_rdy));
            if (g >= 0) begin
                mq.push_back('{due: cyc + 2, idx: g,
                               res: model_cmp(req_x1[g*32 +: 32], req_x2[g*32 +: 32],
                                              req_op[g*2 +: 2])});
                m_ptr = (g + 1) % NREQ;
                m_cnt++;
            end
            while (mq.size() > 0 && mq[0].due <= cyc) void'(mq.pop_front());
        end
    end

    // ---------------- stimulus ----------------
    logic [31:0] pool [12] = '{32'h0000_0000, 32'h8000_0000, 32'h0000_0001, 32'h8000_0001,
                               32'h3F80_0000, 32'hBF80_0000, 32'h4000_0000, 32'hC000_0000,
                               32'h7F80_0000, 32'hFF80_0000, 32'h7FC0_0000, 32'hFFFF_FFFF};

    function automatic logic [31:0] rand_fp();
        if ($urandom_range(0, 3) == 0) return pool[$urandom_range(0, 11)];
        return $urandom;
    endfunction

    // One operation on requester 0 from an idle bus; checks grant, latency and result.
    task automatic single(input string nm, input logic [31:0] a, input logic [31:0] b,
                          input logic [1:0] op, input logic [31:0] exp_y);
        req_valid    = 4'b0001;
        req_x1[31:0] = a;
        req_x2[31:0] = b;
        req_op[1:0]  = op;
        @(negedge clk);
        check({nm, "_ready"}, 32'(req_ready), 32'h1);
        tick();
        req_valid = '0;
        @(negedge clk);
        check({nm, "_no_early_rsp"}, 32'(rsp_valid), 32'h0);
        tick();
        @(negedge clk);
        check({nm, "_rsp_valid"}, 32'(rsp_valid), 32'h1);
        check({nm, "_rsp_y"}, rsp_y, exp_y);
        tick();
    endtask

    initial begin
        logic [31:0] a;
        req_valid = 4'hF;
        for (int i = 0; i < NREQ; i++) begin
            req_x1[i*32 +: 32] = 32'h3F80_0000;
            req_x2[i*32 +: 32] = 32'h4000_0000;
            req_op[i*2 +: 2]   = 2'b00;
        end
        repeat (3) tick();
        rstn = 1'b1;

        // All four valid from reset: grants rotate 0,1,2,3,... and responses follow two later.
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            check("rr_grant", 32'(req_ready), 32'(1 << (k % 4)));
            if (k >= 2) begin
                check("rr_rsp", 32'(rsp_valid), 32'(1 << ((k - 2) % 4)));
                check("rr_rsp_y", rsp_y, 32'h1);
            end
            tick();
        end
        req_valid = '0;
        repeat (3) tick();

        single("lt_1_2",      32'h3F80_0000, 32'h4000_0000, 2'b00, 32'h1);
        single("eq_m0_den",   32'h8000_0000, 32'h0000_0001, 2'b10, 32'h1);
        single("lt_m1_0",     32'hBF80_0000, 32'h0000_0000, 2'b00, 32'h1);
        single("lt_m2_m1",    32'hC000_0000, 32'hBF80_0000, 2'b00, 32'h1);
        single("op_rsv",      32'h3F80_0000, 32'h4000_0000, 2'b11, 32'h0);
        single("lt_2_1",      32'h4000_0000, 32'h3F80_0000, 2'b00, 32'h0);
        single("le_2_2",      32'h4000_0000, 32'h4000_0000, 2'b01, 32'h1);

        // Pointer scenario: grant 1 leaves ptr=2; then {1,3} valid -> 3 then 1; ptr back to 2.
        req_valid = 4'b0010;
        @(negedge clk);
        check("ptr_set", 32'(req_ready), 32'b0010);
        tick();
        req_valid = 4'b1010;
        @(negedge clk);
        check("ptr_g3", 32'(req_ready), 32'b1000);
        tick();
        @(negedge clk);
        check("ptr_g1", 32'(req_ready), 32'b0010);
        tick();
        req_valid = 4'b0101;
        @(negedge clk);
        check("ptr_end2", 32'(req_ready), 32'b0100);
        tick();
        req_valid = '0;
        repeat (3) tick();

        // Randomized traffic against the model.
        for (int n = 0; n < 1500; n++) begin
            req_valid = 4'($urandom_range(0, 15));
            for (int i = 0; i < NREQ; i++) begin
                a = rand_fp();
                req_x1[i*32 +: 32] = a;
                req_x2[i*32 +: 32] = ($urandom_range(0, 7) == 0) ? a : rand_fp();
                req_op[i*2 +: 2]   = 2'($urandom_range(0, 3));
            end
            tick();
        end
        req_valid = '0;
        repeat (3) tick();

        // Reset with two operations in flight: both must vanish.
        req_valid = 4'b0001;
        tick();
        req_valid = 4'b0010;
        tick();
        req_valid = 4'hF;
        rstn = 1'b0;
        @(negedge clk);
        check("rip_ready_low", 32'(req_ready), 32'h0);
        tick();
        tick();
        req_valid = '0;
        rstn = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check("rip_no_rsp", 32'(rsp_valid), 32'h0);
            check("rip_busy", 32'(busy), 32'h0);
            check("rip_stat", 32'(stat_cnt), 32'h0);
            tick();
        end
        req_valid = 4'hF;
        @(negedge clk);
        check("rip_ptr0", 32'(req_ready), 32'h1);
        tick();

        // Long saturation run: one accept per cycle.
        repeat (70000) tick();
        @(negedge clk);
`ifdef FCMP_ARB_STATS_EN
        check("stat_sat", 32'(stat_cnt), 32'h0000_FFFF);
`else
        check("stat_off", 32'(stat_cnt), 32'h0);
`endif
        req_valid = '0;
        tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
